// File: rtl/foo_write_arbiter.sv
// foo_write_arbiter: round-robin arbiter that gives one requester at a time
// write ownership of the shared quux register.
// A tenure lasts at most MAX_HOLD writes. Every release passes through one
// IDLE cycle before the next grant.
module foo_write_arbiter #(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*WIDTH-1:0]    wdata,
  output logic [NREQ-1:0]          gnt,
  output logic [$clog2(NREQ)-1:0]  owner,
  output logic                     busy,
  output logic [WIDTH-1:0]         quux,
  output logic                     quux_wr
);

  localparam int IW = $clog2(NREQ);
  localparam int HW = $clog2(MAX_HOLD + 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t            r_state;
  logic [NREQ-1:0]   r_gnt;
  logic [IW-1:0]     r_owner;
  logic [IW-1:0]     r_ptr;
  logic [HW-1:0]     r_hold_cnt;
  logic [WIDTH-1:0]  r_quux;
  logic              r_quux_wr;

  state_t            w_state_next;
  logic [NREQ-1:0]   w_gnt_next;
  logic [IW-1:0]     w_owner_next;
  logic [IW-1:0]     w_ptr_next;
  logic [HW-1:0]     w_hold_cnt_next;
  logic [WIDTH-1:0]  w_quux_next;
  logic              w_quux_wr_next;

  // Candidate k is the requester k positions above the pointer, wrapped.
  logic [IW-1:0]     w_cand_idx [NREQ];
  logic [NREQ-1:0]   w_cand_hit;
  logic [IW-1:0]     w_winner;
  logic [NREQ-1:0]   w_winner_onehot;
  logic              w_any_req;
  logic              w_owner_req;
  logic [WIDTH-1:0]  w_owner_lane;
  logic [IW-1:0]     w_owner_inc;
  logic              w_last_write;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_cand
      logic [IW:0] w_sum;
      assign w_sum          = {1'b0, r_ptr} + (IW+1)'(gi);
      assign w_cand_idx[gi] = (w_sum >= (IW+1)'(NREQ)) ? IW'(w_sum - (IW+1)'(NREQ))
                                                       : IW'(w_sum);
      assign w_cand_hit[gi] = req[w_cand_idx[gi]];
    end
  endgenerate

  // Pick the candidate closest above the pointer; the downward scan lets the
  // lowest offset overwrite the others.
  always_comb begin
    w_winner = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_cand_hit[k]) begin
        w_winner = w_cand_idx[k];
      end
    end
  end

  assign w_winner_onehot = NREQ'(1) << w_winner;
  assign w_any_req       = |req;
  assign w_owner_req     = req[r_owner];
  assign w_owner_lane    = wdata[r_owner*WIDTH +: WIDTH];
  assign w_owner_inc     = (r_owner == IW'(NREQ - 1)) ? '0 : r_owner + 1'b1;
  assign w_last_write    = (r_hold_cnt == HW'(MAX_HOLD - 1));

  // Next-state and next-output logic; quux_wr is a one-cycle write strobe.
  always_comb begin
    w_state_next    = r_state;
    w_gnt_next      = r_gnt;
    w_owner_next    = r_owner;
    w_ptr_next      = r_ptr;
    w_hold_cnt_next = r_hold_cnt;
    w_quux_next     = r_quux;
    w_quux_wr_next  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_state_next    = ST_GRANT;
          w_owner_next    = w_winner;
          w_gnt_next      = w_winner_onehot;
          w_hold_cnt_next = '0;
        end
      end
      ST_GRANT: begin
        if (w_owner_req) begin
          w_quux_next     = w_owner_lane;
          w_quux_wr_next  = 1'b1;
          w_hold_cnt_next = r_hold_cnt + 1'b1;
          if (w_last_write) begin
            w_state_next = ST_IDLE;
            w_gnt_next   = '0;
            w_ptr_next   = w_owner_inc;
          end
        end else begin
          // Owner withdrew: release without writing.
          w_state_next = ST_IDLE;
          w_gnt_next   = '0;
          w_ptr_next   = w_owner_inc;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_gnt_next   = '0;
      end
    endcase
  end

  // State and output registers, cleared asynchronously by rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_gnt      <= '0;
      r_owner    <= '0;
      r_ptr      <= '0;
      r_hold_cnt <= '0;
      r_quux     <= '0;
      r_quux_wr  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_gnt      <= w_gnt_next;
      r_owner    <= w_owner_next;
      r_ptr      <= w_ptr_next;
      r_hold_cnt <= w_hold_cnt_next;
      r_quux     <= w_quux_next;
      r_quux_wr  <= w_quux_wr_next;
    end
  end

  assign gnt     = r_gnt;
  assign owner   = r_owner;
  assign busy    = (r_state == ST_GRANT);
  assign quux    = r_quux;
  assign quux_wr = r_quux_wr;

endmodule

// File: tb/tb_foo_write_arbiter.sv
// Bench for foo_write_arbiter: directed scenarios followed by random traffic,
// all checked cycle by cycle against a tenure-level reference model.
module tb_foo_write_arbiter;

  localparam int NREQ     = 4;
  localparam int WIDTH    = 8;
  localparam int MAX_HOLD = 4;

  logic                   clk;
  logic                   rst_n;
  logic [NREQ-1:0]        req;
  logic [NREQ*WIDTH-1:0]  wdata;
  logic [NREQ-1:0]        gnt;
  logic [1:0]             owner;
  logic                   busy;
  logic [WIDTH-1:0]       quux;
  logic                   quux_wr;

  int checks   = 0;
  int failures = 0;

  // Reference model: whether a tenure is open, who holds it, how many writes
  // it has made, and where the next round-robin search starts.
  bit               m_busy;
  int               m_owner;
  int               m_ptr;
  int               m_writes;
  logic [WIDTH-1:0] m_quux;
  bit               m_wr;

  foo_write_arbiter #(
    .NREQ     (NREQ),
    .WIDTH    (WIDTH),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .wdata   (wdata),
    .gnt     (gnt),
    .owner   (owner),
    .busy    (busy),
    .quux    (quux),
    .quux_wr (quux_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    m_busy   = 0;
    m_owner  = 0;
    m_ptr    = 0;
    m_writes = 0;
    m_quux   = '0;
    m_wr     = 0;
  endfunction

  // One clock edge of the model, using the inputs present at that edge.
  function automatic void model_step(input logic [NREQ-1:0] r, input logic [NREQ*WIDTH-1:0] d);
    if (!m_busy) begin
      m_wr = 0;
      for (int k = 0; k < NREQ; k++) begin
        if (r[(m_ptr + k) % NREQ]) begin
          m_busy   = 1;
          m_owner  = (m_ptr + k) % NREQ;
          m_writes = 0;
          break;
        end
      end
    end else if (r[m_owner]) begin
      m_quux = d[m_owner*WIDTH +: WIDTH];
      m_wr   = 1;
      m_writes++;
      if (m_writes == MAX_HOLD) begin
        m_busy = 0;
        m_ptr  = (m_owner + 1) % NREQ;
      end
    end else begin
      m_wr   = 0;
      m_busy = 0;
      m_ptr  = (m_owner + 1) % NREQ;
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
    end
  endtask

  task automatic check_all(input string phase);
    logic [NREQ-1:0] exp_gnt;
    exp_gnt = m_busy ? (NREQ'(1) << m_owner) : '0;
    check({phase, ".gnt"},     32'(gnt),     32'(exp_gnt));
    check({phase, ".busy"},    32'(busy),    32'(m_busy));
    check({phase, ".owner"},   32'(owner),   32'(m_owner));
    check({phase, ".quux"},    32'(quux),    32'(m_quux));
    check({phase, ".quux_wr"}, 32'(quux_wr), 32'(m_wr));
  endtask

  task automatic tick(input string phase);
    @(posedge clk);
    model_step(req, wdata);
    #1;
    check_all(phase);
  endtask

  task automatic set_lane(input int i, input logic [WIDTH-1:0] v);
    wdata[i*WIDTH +: WIDTH] = v;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    wdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;

    // Single requester 2 with a fixed lane value: grant, 4 writes, bubble, re-grant.
    req = 4'b0100;
    set_lane(2, 8'hA5);
    repeat (12) tick("single");
    req = '0;
    repeat (3) tick("single_idle");

    // Fairness: all request from a fresh reset; order 0,1,2,3,0.
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("fair_rst");
    rst_n = 1'b1;
    req = 4'b1111;
    for (int c = 0; c < 5 * (MAX_HOLD + 2); c++) begin
      wdata = {$urandom, $urandom};
      tick("fair");
    end
    req = '0;
    repeat (3) tick("fair_idle");

    // Early drop by requester 1 after two writes; pointer then sits at 2,
    // so 1011 must go to 3, and after 3 the wrap favours 0.
    req = 4'b0010;
    set_lane(1, 8'h11);
    tick("drop_gnt");
    set_lane(1, 8'h22);
    tick("drop_w1");
    set_lane(1, 8'h33);
    tick("drop_w2");
    req = '0;
    set_lane(1, 8'hEE);
    repeat (2) tick("drop_rel");
    req = 4'b1011;
    repeat (MAX_HOLD + 1) tick("ptr_after_drop");
    req = 4'b1001;
    repeat (MAX_HOLD + 3) tick("wrap");
    req = '0;
    repeat (3) tick("wrap_idle");

    // Asynchronous reset after two writes of 3C.
    req = 4'b0001;
    set_lane(0, 8'h3C);
    repeat (3) tick("areset_pre");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("areset_mid");
    req = 4'b0110;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick("areset_post");
    req = '0;
    repeat (MAX_HOLD + 2) tick("areset_idle");

    // Requester 3 rises during requester 0's tenure and must wait.
    req = 4'b0001;
    set_lane(3, 8'h5A);
    tick("ignore_gnt0");
    req = 4'b1001;
    repeat (MAX_HOLD + 4) tick("ignore");
    req = '0;
    repeat (3) tick("ignore_idle");

    // Random traffic with occasional mid-cycle resets.
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) req = NREQ'($urandom_range(0, 15));
      wdata = {$urandom, $urandom};
      if ($urandom_range(0, 99) == 0) begin
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("rand_rst");
        @(negedge clk);
        rst_n = 1'b1;
      end
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
